// File: rtl/serial_link_pkg.sv
// Shared definitions for the bit-serial link (transmitter and receiver).
// The SERIAL_TX_PARITY_EN macro appends an even-parity bit to every frame.
package serial_link_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int unsigned frame_bits(input int unsigned data_width);
`ifdef SERIAL_TX_PARITY_EN
    return data_width + 1;
`else
    return data_width;
`endif
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register; shifts right and exposes bit 0.
module piso_shift_reg #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_bit0
);

  logic [WIDTH-1:0] r_shreg;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_shreg <= '0;
    end else if (i_en) begin
      if (i_load) begin
        r_shreg <= i_data;
      end else if (i_shift) begin
        r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
      end
    end
  end

  assign o_bit0 = r_shreg[0];

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial transmitter, LSB first, over the serial valid/ready link.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit after the MSB.
module serial_word_tx
  import serial_link_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic                  i_word_valid,
  output logic                  o_word_ready,
  output logic                  o_dout_valid,
  input  logic                  i_ready,
  output logic                  o_dout
);

  localparam int unsigned FRAME_BITS = frame_bits(DATA_WIDTH);
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

  state_e                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_dout;
  logic                  r_dout_valid;
  logic                  w_accept;
  logic                  w_shift;
  logic                  w_bit0;
  logic [FRAME_BITS-1:0] w_load_data;

`ifdef SERIAL_TX_PARITY_EN
  assign w_load_data = {^i_word, i_word};
`else
  assign w_load_data = i_word;
`endif

  assign o_word_ready = i_rst && i_en && (r_state == ST_IDLE);
  assign w_accept     = o_word_ready && i_word_valid;
  // The register always presents the next bit at bit 0, so shift at E and every SHIFT edge.
  assign w_shift      = ((r_state == ST_REQ) && i_ready) || (r_state == ST_SHIFT);

  piso_shift_reg #(
    .WIDTH (FRAME_BITS)
  ) u_piso (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_en),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (w_load_data),
    .o_bit0  (w_bit0)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
    end else if (i_en) begin
      case (r_state)
        ST_IDLE: begin
          if (i_word_valid) begin
            r_state      <= ST_REQ;
            r_dout_valid <= 1'b1;
          end
        end
        ST_REQ: begin
          if (i_ready) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
            r_dout  <= w_bit0;
          end
        end
        ST_SHIFT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_state      <= ST_DONE;
            r_dout       <= 1'b0;
            r_dout_valid <= 1'b0;
          end else begin
            r_dout <= w_bit0;
          end
        end
        ST_DONE: begin
          // Wait for the receiver to drop ready so a held ready cannot start the next frame.
          if (!i_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench for serial_word_tx: vector table, hand sequences, random frames.
module tb_serial_word_tx;

  localparam int unsigned DW = 24;
`ifdef SERIAL_TX_PARITY_EN
  localparam int unsigned FB = DW + 1;
`else
  localparam int unsigned FB = DW;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] word;
  logic          word_valid;
  logic          word_ready;
  logic          dout_valid;
  logic          ready;
  logic          dout;

  int n_checks = 0;
  int n_errors = 0;

  serial_word_tx #(
    .DATA_WIDTH (DW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_word       (word),
    .i_word_valid (word_valid),
    .o_word_ready (word_ready),
    .o_dout_valid (dout_valid),
    .i_ready      (ready),
    .o_dout       (dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] word;
    int            rdy_delay;
    bit            stall;
    logic [DW-1:0] exp_bits;
    logic          exp_par;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: frame is the word LSB first, optionally followed by even parity.
  function automatic logic [31:0] model_frame(input logic [DW-1:0] w);
    logic [31:0] f;
    int ones;
    f    = '0;
    ones = 0;
    for (int k = 0; k < DW; k++) begin
      f[k] = w[k];
      ones += int'(w[k]);
    end
`ifdef SERIAL_TX_PARITY_EN
    f[DW] = (ones % 2) == 1;
`endif
    return f;
  endfunction

  function automatic logic [31:0] vec_frame(input vec_t v);
    logic [31:0] f;
    f = 32'(v.exp_bits);
`ifdef SERIAL_TX_PARITY_EN
    f[DW] = v.exp_par;
`endif
    return f;
  endfunction

  // Drives one word through accept, REQ wait, and FB bit cycles, collecting the serial bits.
  task automatic run_frame(input logic [DW-1:0] w, input int rdy_delay, input bit stall,
                           input bit hold_ready, output logic [31:0] got);
    int  t;
    bit  vld_ok;
    got        = '0;
    word       = w;
    word_valid = 1'b1;
    t          = 0;
    #1;
    while (!word_ready && t < 50) begin
      tick();
      t++;
    end
    if (!word_ready) begin
      check("accept_timeout", 32'(word_ready), 32'd1);
      word_valid = 1'b0;
      return;
    end
    tick();
    word_valid = 1'b0;
    check("valid_after_accept", 32'(dout_valid), 32'd1);
    check("ready_low_in_req", 32'(word_ready), 32'd0);
    if (stall) begin
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        check("stall_valid_hold", 32'(dout_valid), 32'd1);
        check("stall_word_ready", 32'(word_ready), 32'd0);
      end
      en = 1'b1;
    end
    for (int i = 0; i < rdy_delay; i++) begin
      tick();
      check("req_valid_hold", 32'(dout_valid), 32'd1);
    end
    ready = 1'b1;
    tick();
    vld_ok = 1'b1;
    for (int k = 0; k < int'(FB); k++) begin
      got[k] = dout;
      if (dout_valid !== 1'b1) vld_ok = 1'b0;
      tick();
    end
    check("valid_through_frame", 32'(vld_ok), 32'd1);
    check("valid_fall", 32'(dout_valid), 32'd0);
    check("dout_zero_done", 32'(dout), 32'd0);
    if (!hold_ready) begin
      ready = 1'b0;
      tick();
    end
  endtask

  initial begin
    logic [31:0]   got;
    logic [DW-1:0] w;
    logic [DW-1:0] aa;

    vecs[0] = '{word: 24'h7FFFFF, rdy_delay: 5, stall: 1'b0, exp_bits: 24'h7FFFFF, exp_par: 1'b1};
    vecs[1] = '{word: 24'h000007, rdy_delay: 0, stall: 1'b0, exp_bits: 24'h000007, exp_par: 1'b1};
    vecs[2] = '{word: 24'h000003, rdy_delay: 2, stall: 1'b0, exp_bits: 24'h000003, exp_par: 1'b0};
    vecs[3] = '{word: 24'h000F0F, rdy_delay: 1, stall: 1'b0, exp_bits: 24'h000F0F, exp_par: 1'b0};
    vecs[4] = '{word: 24'hAAAAAA, rdy_delay: 3, stall: 1'b1, exp_bits: 24'hAAAAAA, exp_par: 1'b0};
    vecs[5] = '{word: 24'h800001, rdy_delay: 0, stall: 1'b0, exp_bits: 24'h800001, exp_par: 1'b0};

    rst        = 1'b0;
    en         = 1'b1;
    word       = '0;
    word_valid = 1'b1;
    ready      = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_word_ready", 32'(word_ready), 32'd0);
      check("rst_dout_valid", 32'(dout_valid), 32'd0);
      check("rst_dout", 32'(dout), 32'd0);
    end
    word_valid = 1'b0;
    rst        = 1'b1;
    #1;
    check("word_ready_after_rst", 32'(word_ready), 32'd1);
    en = 1'b0;
    #1;
    check("word_ready_en_low", 32'(word_ready), 32'd0);
    en = 1'b1;
    tick();

    foreach (vecs[i]) begin
      run_frame(vecs[i].word, vecs[i].rdy_delay, vecs[i].stall, 1'b0, got);
      check($sformatf("vec%0d_frame", i), got, vec_frame(vecs[i]));
    end

    // Back-to-back with ready held high: next frame waits for ready to drop.
    run_frame(24'h800001, 0, 1'b0, 1'b1, got);
    check("b2b_first_frame", got, model_frame(24'h800001));
    word       = 24'h123456;
    word_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b2b_held_word_ready", 32'(word_ready), 32'd0);
      check("b2b_held_dout_valid", 32'(dout_valid), 32'd0);
    end
    ready = 1'b0;
    tick();
    check("b2b_word_ready_return", 32'(word_ready), 32'd1);
    run_frame(24'h123456, 0, 1'b0, 1'b0, got);
    check("b2b_second_frame", got, model_frame(24'h123456));

    // Reset after bit 10 of a frame aborts it; the next word goes through cleanly.
    aa         = 24'hAAAAAA;
    word       = aa;
    word_valid = 1'b1;
    #1;
    check("midrst_idle_ready", 32'(word_ready), 32'd1);
    tick();
    word_valid = 1'b0;
    ready      = 1'b1;
    tick();
    got = '0;
    for (int k = 0; k <= 10; k++) begin
      got[k] = dout;
      tick();
    end
    check("midrst_partial_bits", got & 32'h7FF, 32'(aa) & 32'h7FF);
    rst = 1'b0;
    tick();
    check("midrst_dout_valid", 32'(dout_valid), 32'd0);
    check("midrst_dout", 32'(dout), 32'd0);
    check("midrst_word_ready", 32'(word_ready), 32'd0);
    rst   = 1'b1;
    ready = 1'b0;
    #1;
    check("midrst_release_ready", 32'(word_ready), 32'd1);
    run_frame(24'h000F0F, 2, 1'b0, 1'b0, got);
    check("after_rst_frame", got, model_frame(24'h000F0F));

    for (int i = 0; i < 25; i++) begin
      w = DW'($urandom);
      run_frame(w, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b0, got);
      check($sformatf("rand%0d_frame", i), got, model_frame(w));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
